// File: rtl/id_and_rf.sv
// id_and_rf: RV64 instruction decode stage with integrated 32 x 64-bit
// register file and ID/EX pipeline register.
// Optional build macro IDRF_WB_BYPASS_EN: when defined, a write-back landing
// in the same cycle as a read of the same register is forwarded to the read
// ports (write-through). When undefined, the read returns the old value and
// the new value becomes visible one cycle later.
module id_and_rf (
  input  logic        clk,
  input  logic        reset_receive,
  input  logic [63:0] pc_receive,
  input  logic [31:0] instruction_receive,
  input  logic        regWrite_receive,
  input  logic [63:0] writeData_receive,
  output logic [63:0] pc,
  output logic [63:0] extended,
  output logic [3:0]  Func,
  output logic [63:0] read_data_1,
  output logic [63:0] read_data_2,
  output logic        regWrite_out,
  output logic        ALU_Src,
  output logic        Mem_Write,
  output logic        Mem_to_Reg,
  output logic        Mem_Read,
  output logic        Branch,
  output logic [1:0]  ALU_Op
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [63:0] r_regs [0:31];
  logic [4:0]  r_rd_pipe [0:3];

  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [7:0]  w_ctrl;
  logic [63:0] w_imm;
  logic [63:0] w_rdata1;
  logic [63:0] w_rdata2;
  logic [4:0]  w_wr_rd;
  logic        w_wr_en;

  assign w_opcode = instruction_receive[6:0];
  assign w_rs1    = instruction_receive[19:15];
  assign w_rs2    = instruction_receive[24:20];
  assign w_rd     = instruction_receive[11:7];

  // The oldest delay-line entry is the destination of the data arriving now;
  // x0 is never written so its storage stays at zero.
  assign w_wr_rd = r_rd_pipe[3];
  assign w_wr_en = regWrite_receive && (w_wr_rd != 5'd0);

  // Opcode decode: {regWrite, ALU_Src, Mem_Write, Mem_to_Reg, Mem_Read, Branch, ALU_Op}
  always_comb begin
    w_ctrl = 8'b0000_0000;
    unique case (w_opcode)
      OP_RTYPE:  w_ctrl = 8'b1000_0010;
      OP_IALU:   w_ctrl = 8'b1100_0011;
      OP_LOAD:   w_ctrl = 8'b1101_1000;
      OP_STORE:  w_ctrl = 8'b0110_0000;
      OP_BRANCH: w_ctrl = 8'b0000_0101;
      default:   w_ctrl = 8'b0000_0000;
    endcase
  end

  // Immediate generation; branch offset is already a byte offset (bit 0 = 0).
  always_comb begin
    w_imm = 64'd0;
    unique case (w_opcode)
      OP_IALU, OP_LOAD:
        w_imm = {{52{instruction_receive[31]}}, instruction_receive[31:20]};
      OP_STORE:
        w_imm = {{52{instruction_receive[31]}}, instruction_receive[31:25],
                 instruction_receive[11:7]};
      OP_BRANCH:
        w_imm = {{51{instruction_receive[31]}}, instruction_receive[31],
                 instruction_receive[7], instruction_receive[30:25],
                 instruction_receive[11:8], 1'b0};
      default:
        w_imm = 64'd0;
    endcase
  end

  // Combinational register read, x0 hardwired to zero, optional write-through.
  always_comb begin
    w_rdata1 = (w_rs1 == 5'd0) ? 64'd0 : r_regs[w_rs1];
    w_rdata2 = (w_rs2 == 5'd0) ? 64'd0 : r_regs[w_rs2];
`ifdef IDRF_WB_BYPASS_EN
    if (w_wr_en && (w_wr_rd == w_rs1)) w_rdata1 = writeData_receive;
    if (w_wr_en && (w_wr_rd == w_rs2)) w_rdata2 = writeData_receive;
`else
    // Reads see the pre-write contents; the write lands at the edge.
`endif
  end

  // Register file storage, cleared on reset so no stale data survives.
  always_ff @(posedge clk or negedge reset_receive) begin
    if (!reset_receive) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 64'd0;
    end else if (w_wr_en) begin
      r_regs[w_wr_rd] <= writeData_receive;
    end
  end

  // rd delay line; non-writing instructions insert rd = 0 so bubbles and
  // stores/branches can never target a register.
  always_ff @(posedge clk or negedge reset_receive) begin
    if (!reset_receive) begin
      for (int i = 0; i < 4; i++) r_rd_pipe[i] <= 5'd0;
    end else begin
      r_rd_pipe[0] <= w_ctrl[7] ? w_rd : 5'd0;
      r_rd_pipe[1] <= r_rd_pipe[0];
      r_rd_pipe[2] <= r_rd_pipe[1];
      r_rd_pipe[3] <= r_rd_pipe[2];
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge reset_receive) begin
    if (!reset_receive) begin
      pc           <= 64'd0;
      extended     <= 64'd0;
      Func         <= 4'd0;
      read_data_1  <= 64'd0;
      read_data_2  <= 64'd0;
      regWrite_out <= 1'b0;
      ALU_Src      <= 1'b0;
      Mem_Write    <= 1'b0;
      Mem_to_Reg   <= 1'b0;
      Mem_Read     <= 1'b0;
      Branch       <= 1'b0;
      ALU_Op       <= 2'b00;
    end else begin
      pc           <= pc_receive;
      extended     <= w_imm;
      Func         <= {instruction_receive[30], instruction_receive[14:12]};
      read_data_1  <= w_rdata1;
      read_data_2  <= w_rdata2;
      regWrite_out <= w_ctrl[7];
      ALU_Src      <= w_ctrl[6];
      Mem_Write    <= w_ctrl[5];
      Mem_to_Reg   <= w_ctrl[4];
      Mem_Read     <= w_ctrl[3];
      Branch       <= w_ctrl[2];
      ALU_Op       <= w_ctrl[1:0];
    end
  end

endmodule

// File: tb/tb_id_and_rf.sv
// Testbench for id_and_rf: behavioural model (register array + queue of
// pending destinations) compared every cycle, plus literal expectations.
module tb_id_and_rf;

  logic        clk = 1'b0;
  logic        reset_receive;
  logic [63:0] pc_receive;
  logic [31:0] instruction_receive;
  logic        regWrite_receive;
  logic [63:0] writeData_receive;
  logic [63:0] pc, extended, read_data_1, read_data_2;
  logic [3:0]  Func;
  logic        regWrite_out, ALU_Src, Mem_Write, Mem_to_Reg, Mem_Read, Branch;
  logic [1:0]  ALU_Op;

  id_and_rf dut (
    .clk(clk), .reset_receive(reset_receive), .pc_receive(pc_receive),
    .instruction_receive(instruction_receive), .regWrite_receive(regWrite_receive),
    .writeData_receive(writeData_receive), .pc(pc), .extended(extended), .Func(Func),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .regWrite_out(regWrite_out),
    .ALU_Src(ALU_Src), .Mem_Write(Mem_Write), .Mem_to_Reg(Mem_to_Reg),
    .Mem_Read(Mem_Read), .Branch(Branch), .ALU_Op(ALU_Op)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [63:0] mregs [32];
  logic [4:0]  rdq [$];
  logic [63:0] e_pc, e_ext, e_r1, e_r2;
  logic [3:0]  e_func;
  logic [7:0]  e_ctrl;
  logic        chk_en = 1'b0;

  wire [7:0] w_dut_ctrl = {regWrite_out, ALU_Src, Mem_Write, Mem_to_Reg, Mem_Read, Branch, ALU_Op};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Control tuple from the opcode table: {regWrite,ALUSrc,MemWrite,MemToReg,MemRead,Branch,ALUOp}
  function automatic logic [7:0] m_ctrl(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
      7'b0010011: return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11};
      7'b0000011: return {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00};
      7'b0100011: return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      7'b1100011: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
      default:    return 8'd0;
    endcase
  endfunction

  // Immediate value as a signed integer, built from the field layout.
  function automatic logic [63:0] m_imm(input logic [31:0] ins);
    longint v;
    logic signed [11:0] i12;
    logic signed [11:0] b12;
    v = 0;
    case (ins[6:0])
      7'b0010011, 7'b0000011: begin i12 = ins[31:20]; v = i12; end
      7'b0100011: begin i12 = {ins[31:25], ins[11:7]}; v = i12; end
      7'b1100011: begin b12 = {ins[31], ins[7], ins[30:25], ins[11:8]}; v = b12; v = v * 2; end
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] rs, input logic we,
                                         input logic [4:0] wr_rd, input logic [63:0] wd);
    if (rs == 5'd0) return 64'd0;
`ifdef IDRF_WB_BYPASS_EN
    if (we && wr_rd == rs) return wd;
`endif
    return mregs[rs];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    rdq = '{5'd0, 5'd0, 5'd0, 5'd0};
  endtask

  // Present one instruction before the next rising edge, then advance the model.
  task automatic step(input logic [31:0] ins, input logic [63:0] pcv,
                      input logic we, input logic [63:0] wd);
    logic [4:0]  wr_rd;
    logic [7:0]  c;
    logic [63:0] n_ext, n_r1, n_r2;
    @(negedge clk);
    instruction_receive = ins;
    pc_receive          = pcv;
    regWrite_receive    = we;
    writeData_receive   = wd;
    wr_rd = rdq[0];
    c     = m_ctrl(ins);
    n_ext = m_imm(ins);
    n_r1  = m_read(ins[19:15], we, wr_rd, wd);
    n_r2  = m_read(ins[24:20], we, wr_rd, wd);
    @(posedge clk);
    #1;
    e_pc = pcv; e_ext = n_ext; e_func = {ins[30], ins[14:12]};
    e_ctrl = c; e_r1 = n_r1; e_r2 = n_r2;
    if (we && wr_rd != 5'd0) mregs[wr_rd] = wd;
    void'(rdq.pop_front());
    rdq.push_back(c[7] ? ins[11:7] : 5'd0);
    chk_en = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc"},  pc, 64'd0);
    chk({tag, "_ext"}, extended, 64'd0);
    chk({tag, "_func"}, {60'd0, Func}, 64'd0);
    chk({tag, "_rd1"}, read_data_1, 64'd0);
    chk({tag, "_rd2"}, read_data_2, 64'd0);
    chk({tag, "_ctrl"}, {56'd0, w_dut_ctrl}, 64'd0);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, e_pc);
      chk("extended", extended, e_ext);
      chk("Func", {60'd0, Func}, {60'd0, e_func});
      chk("read_data_1", read_data_1, e_r1);
      chk("read_data_2", read_data_2, e_r2);
      chk("controls", {56'd0, w_dut_ctrl}, {56'd0, e_ctrl});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    logic [6:0]  opcs [7];
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0000000, 7'b1101111};

    // Reset held with live-looking inputs, including a write request.
    reset_receive       = 1'b0;
    pc_receive          = 64'h1234;
    instruction_receive = 32'h00A00093;
    regWrite_receive    = 1'b1;
    writeData_receive   = 64'hFFFF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset_receive    = 1'b1;
    regWrite_receive = 1'b0;

    // Every register reads zero after reset.
    for (int i = 1; i < 32; i++) begin
      step((32'(i) << 20) | (32'(i) << 15) | 32'h33, 64'd0, 1'b0, 64'd0);
      chk("reset_read_rs1", read_data_1, 64'd0);
      chk("reset_read_rs2", read_data_2, 64'd0);
    end

    // addi x1,x0,10 decode, then write-back of 0x2A four edges later.
    step(32'h00A00093, 64'h4, 1'b0, 64'd0);
    chk("addi_ctrl", {56'd0, w_dut_ctrl}, 64'hC3);
    chk("addi_ext", extended, 64'd10);
    chk("addi_func", {60'd0, Func}, 64'd0);
    chk("addi_pc", pc, 64'h4);
    repeat (3) step(32'h0, 64'h8, 1'b0, 64'd0);
    step(32'h0, 64'hC, 1'b1, 64'h2A);
    step(32'h002082B3, 64'h10, 1'b0, 64'd0);
    chk("wb_x1", read_data_1, 64'h2A);

    // Store and branch immediates.
    step(32'hFE20BC23, 64'h14, 1'b0, 64'd0);
    chk("sd_memwrite", {63'd0, Mem_Write}, 64'd1);
    chk("sd_ext", extended, 64'hFFFF_FFFF_FFFF_FFF8);
    step(32'hFE208EE3, 64'h18, 1'b0, 64'd0);
    chk("beq_branch", {63'd0, Branch}, 64'd1);
    chk("beq_aluop", {62'd0, ALU_Op}, 64'd1);
    chk("beq_ext", extended, 64'hFFFF_FFFF_FFFF_FFFC);

    // Write aimed at x0 is dropped; all-zero word is a bubble.
    step(32'h00500013, 64'h1C, 1'b0, 64'd0);
    repeat (3) step(32'h0, 64'h20, 1'b0, 64'd0);
    step(32'h0, 64'h24, 1'b1, 64'h55);
    chk("bubble_ctrl", {56'd0, w_dut_ctrl}, 64'd0);
    step(32'h00000033, 64'h28, 1'b0, 64'd0);
    chk("x0_read", read_data_1, 64'd0);

    // Same-cycle write/read of x3.
    step(32'h00300193, 64'h2C, 1'b0, 64'd0);
    repeat (3) step(32'h0, 64'h30, 1'b0, 64'd0);
    step(32'h0, 64'h34, 1'b1, 64'h11);
    step(32'h00300193, 64'h38, 1'b0, 64'd0);
    repeat (3) step(32'h0, 64'h3C, 1'b0, 64'd0);
    step(32'h00018033, 64'h40, 1'b1, 64'h77);
`ifdef IDRF_WB_BYPASS_EN
    chk("bypass_x3", read_data_1, 64'h77);
`else
    chk("nobypass_x3", read_data_1, 64'h11);
`endif
    step(32'h00018033, 64'h44, 1'b0, 64'd0);
    chk("x3_after", read_data_1, 64'h77);

    // Reset mid-operation drops the pending write to x7.
    step(32'h00100393, 64'h48, 1'b0, 64'd0);
    step(32'h0, 64'h4C, 1'b0, 64'd0);
    @(negedge clk);
    chk_en        = 1'b0;
    reset_receive = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk);
    @(negedge clk);
    reset_receive = 1'b1;
    model_reset();
    repeat (4) step(32'h0, 64'h50, 1'b1, 64'hDEAD);
    step(32'h00038033, 64'h54, 1'b0, 64'd0);
    chk("midreset_x7", read_data_1, 64'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      ins = $urandom;
      ins[6:0] = opcs[$urandom_range(0, 6)];
      if ($urandom_range(0, 1) == 1) begin
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
      end
      step(ins, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           {$urandom, $urandom});
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
